// File: rtl/pln_mem_pkg.sv
// Shared address map, STATUS layout and region decode for the PLN data-memory responder.
// Pure declarations: no latency and no backpressure of its own.
package pln_mem_pkg;

  localparam logic [15:0] MMIO_BASE   = 16'hFF00;
  localparam logic [15:0] GPIO_ADDR   = 16'hFF00;
  localparam logic [15:0] TX_ADDR     = 16'hFF01;
  localparam logic [15:0] STATUS_ADDR = 16'hFF02;
  localparam logic [15:0] CYCLES_ADDR = 16'hFF03;

  localparam int ST_COUNT_W = 5;
  localparam int ST_FULL    = 5;
  localparam int ST_EMPTY   = 6;
  localparam int ST_OVF     = 7;
  localparam int ST_UNMAP   = 8;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAP
  } region_e;

  // RAM sits at the bottom of the space, so the RAM depth bounds the RAM region.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int unsigned ram_depth);
    if ({16'd0, addr} < ram_depth) begin
      return REG_RAM;
    end else if (addr >= MMIO_BASE && addr <= CYCLES_ADDR) begin
      return REG_MMIO;
    end else begin
      return REG_UNMAP;
    end
  endfunction

endpackage

// File: rtl/pln_tx_fifo.sv
// Small FIFO with push/pop strobes, count and full/empty flags; head visible combinationally.
// Latency: a pushed entry appears at the head on the following cycle.
// Backpressure: push while full is dropped (judged on pre-pop count); pop while empty is ignored.
module pln_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = empty ? '0 : mem_q[rd_ptr];

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= push_dat;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/pln_dmem_responder.sv
// CPU data-memory responder: word RAM plus GPIO/TX/STATUS/CYCLES MMIO window.
// Latency: load data registered on the request edge, valid the next cycle; never stalls.
// Backpressure: none toward the CPU; TX bytes drain on tx_valid&tx_ready, overflow is sticky.
module pln_dmem_responder
  import pln_mem_pkg::*;
#(
  parameter int RAM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        mem_we,
  output logic [15:0] mem_rdata,
  output logic [15:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  region_e           region;
  logic              is_load;
  logic              is_store;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       ram [RAM_DEPTH];

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic              ovf_flag;
  logic              unmap_flag;
  logic              ovf_set;
  logic              unmap_set;
  logic              status_rd;
  logic [15:0]       status_word;
  logic [15:0]       cycles;
  logic [15:0]       load_dat;

  assign region   = decode_region(mem_addr, RAM_DEPTH);
  assign is_load  = mem_req & ~mem_we;
  assign is_store = mem_req & mem_we;
  assign ram_idx  = mem_addr[RAM_AW-1:0];

  assign fifo_push = is_store & (mem_addr == TX_ADDR);
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;

  assign ovf_set   = fifo_push & fifo_full;
  assign unmap_set = mem_req & (region == REG_UNMAP);
  assign status_rd = is_load & (mem_addr == STATUS_ADDR);

  pln_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (mem_wdata[7:0]),
    .pop      (fifo_pop),
    .head_dat (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status_word                   = '0;
    status_word[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
    status_word[ST_FULL]          = fifo_full;
    status_word[ST_EMPTY]         = fifo_empty;
    status_word[ST_OVF]           = ovf_flag;
    status_word[ST_UNMAP]         = unmap_flag;
  end

  always_comb begin
    load_dat = '0;
    case (region)
      REG_RAM: load_dat = ram[ram_idx];
      REG_MMIO: begin
        case (mem_addr)
          GPIO_ADDR:   load_dat = gpio_out;
          STATUS_ADDR: load_dat = status_word;
          CYCLES_ADDR: load_dat = cycles;
          default:     load_dat = '0;
        endcase
      end
      default: load_dat = '0;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (is_store && region == REG_RAM) begin
      ram[ram_idx] <= mem_wdata;
    end
  end

  // A set event outranks the read-clear; both cannot coincide with one request, but keep the order explicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata  <= '0;
      gpio_out   <= '0;
      ovf_flag   <= 1'b0;
      unmap_flag <= 1'b0;
      cycles     <= '0;
    end else begin
      cycles <= cycles + 16'd1;
      if (is_load) begin
        mem_rdata <= load_dat;
      end
      if (is_store && mem_addr == GPIO_ADDR) begin
        gpio_out <= mem_wdata;
      end
      ovf_flag   <= ovf_set   | (ovf_flag   & ~status_rd);
      unmap_flag <= unmap_set | (unmap_flag & ~status_rd);
    end
  end

endmodule

// File: tb/tb_pln_dmem_responder.sv
// Randomised and directed bench for pln_dmem_responder against a queue/array reference model.
module tb_pln_dmem_responder;

  localparam int RAM_DEPTH  = 256;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] mem_wdata = 16'h0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_rdata;
  logic [15:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  pln_dmem_responder #(
    .RAM_DEPTH  (RAM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .gpio_out  (gpio_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ram_m [int];
  logic [15:0] gpio_m = 16'h0;
  logic [15:0] rdata_m = 16'h0;
  logic [15:0] cyc_m = 16'h0;
  logic        ovf_m = 1'b0;
  logic        unm_m = 1'b0;
  logic [7:0]  q [$];

  function automatic logic [15:0] status_m();
    logic [15:0] s;
    s      = 16'h0;
    s[4:0] = 5'(q.size());
    s[5]   = (q.size() == FIFO_DEPTH);
    s[6]   = (q.size() == 0);
    s[7]   = ovf_m;
    s[8]   = unm_m;
    return s;
  endfunction

  function automatic logic [7:0] head_m();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  // One clock: drive at negedge, advance the model, return 1 time unit after the posedge.
  task automatic step(input logic req, input logic [15:0] a, input logic [15:0] wd,
                      input logic we, input logic rdy);
    logic        full_pre;
    logic        do_push;
    logic [15:0] ld;
    @(negedge clk);
    rst = 1'b0; mem_req = req; mem_addr = a; mem_wdata = wd; mem_we = we; tx_ready = rdy;
    full_pre = (q.size() == FIFO_DEPTH);
    do_push  = 1'b0;
    ld       = 16'h0;
    if (req) begin
      if (int'(a) < RAM_DEPTH) begin
        if (we) ram_m[int'(a)] = wd;
        else ld = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'h0;
      end else if (a == 16'hFF00) begin
        if (we) gpio_m = wd;
        else ld = gpio_m;
      end else if (a == 16'hFF01) begin
        if (we) begin
          if (full_pre) ovf_m = 1'b1;
          else do_push = 1'b1;
        end
      end else if (a == 16'hFF02) begin
        if (!we) begin
          ld = status_m();
          ovf_m = 1'b0;
          unm_m = 1'b0;
        end
      end else if (a == 16'hFF03) begin
        if (!we) ld = cyc_m;
      end else begin
        unm_m = 1'b1;
      end
      if (!we) rdata_m = ld;
    end
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (do_push) q.push_back(wd[7:0]);
    cyc_m = cyc_m + 16'd1;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; mem_req = 1'b0; tx_ready = rdy;
    @(posedge clk);
    #1;
    q.delete();
    ovf_m = 1'b0; unm_m = 1'b0; gpio_m = 16'h0; rdata_m = 16'h0; cyc_m = 16'h0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (mem_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", mem_rdata); end
    checks++; if (gpio_out !== 16'h0) begin errors++; $display("FAIL reset_gpio got %h exp 0000", gpio_out); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0040) begin errors++; $display("FAIL reset_status got %h exp 0040", mem_rdata); end
    step(1'b1, 16'hFF03, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0001) begin errors++; $display("FAIL reset_cycles got %h exp 0001", mem_rdata); end
  endtask

  task automatic test_ram();
    step(1'b1, 16'h0005, 16'h1234, 1'b1, 1'b0);
    step(1'b1, 16'h0005, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h1234) begin errors++; $display("FAIL ram_load got %h exp 1234", mem_rdata); end
    step(1'b1, 16'h0006, 16'hAAAA, 1'b1, 1'b0);
    checks++; if (mem_rdata !== 16'h1234) begin errors++; $display("FAIL ram_hold_store got %h exp 1234", mem_rdata); end
    step(1'b0, 16'h0007, 16'h5555, 1'b1, 1'b0);
    checks++; if (mem_rdata !== 16'h1234) begin errors++; $display("FAIL ram_hold_idle got %h exp 1234", mem_rdata); end
    step(1'b1, 16'h00FF, 16'hC0DE, 1'b1, 1'b0);
    step(1'b1, 16'h0006, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'hAAAA) begin errors++; $display("FAIL ram_load2 got %h exp aaaa", mem_rdata); end
    step(1'b1, 16'h00FF, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'hC0DE) begin errors++; $display("FAIL ram_top got %h exp c0de", mem_rdata); end
  endtask

  task automatic test_gpio();
    step(1'b1, 16'hFF00, 16'hBEEF, 1'b1, 1'b0);
    checks++; if (gpio_out !== 16'hBEEF) begin errors++; $display("FAIL gpio_out got %h exp beef", gpio_out); end
    step(1'b1, 16'hFF00, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'hBEEF) begin errors++; $display("FAIL gpio_load got %h exp beef", mem_rdata); end
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 5; i++) step(1'b1, 16'hFF01, 16'(8'h41 + i), 1'b1, 1'b0);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL fill_head got %b/%h exp 1/41", tx_valid, tx_data); end
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h00A4) begin errors++; $display("FAIL ovf_status got %h exp 00a4", mem_rdata); end
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0024) begin errors++; $display("FAIL ovf_cleared got %h exp 0024", mem_rdata); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL drain_byte%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin errors++; $display("FAIL drain_empty got %b/%h exp 0/00", tx_valid, tx_data); end
  endtask

  task automatic test_unmapped();
    step(1'b1, 16'h9000, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0) begin errors++; $display("FAIL unmap_load got %h exp 0000", mem_rdata); end
    step(1'b1, 16'h0100, 16'h7777, 1'b1, 1'b0);
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0140) begin errors++; $display("FAIL unmap_status got %h exp 0140", mem_rdata); end
    step(1'b1, 16'hFF02, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 16'hFF03, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0040) begin errors++; $display("FAIL unmap_cleared got %h exp 0040", mem_rdata); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) step(1'b1, 16'hFF01, 16'(8'h41 + i), 1'b1, 1'b0);
    step(1'b1, 16'hFF01, 16'h0055, 1'b1, 1'b1);
    checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL fullpop_head got %h exp 42", tx_data); end
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0083) begin errors++; $display("FAIL fullpop_status got %h exp 0083", mem_rdata); end
    step(1'b1, 16'hFF01, 16'h0066, 1'b1, 1'b1);
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0003) begin errors++; $display("FAIL pushpop_status got %h exp 0003", mem_rdata); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== (q.size() > 0) || tx_data !== head_m()) begin
        errors++; $display("FAIL pushpop_drain got %b/%h exp %b/%h", tx_valid, tx_data, q.size() > 0, head_m());
      end
      if (q.size() > 0) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_cycles();
    int k;
    do_reset(1'b0);
    step(1'b1, 16'hFF03, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'h0) begin errors++; $display("FAIL cycles_first got %h exp 0000", mem_rdata); end
    k = $urandom_range(3, 20);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'hFF03, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== 16'(k + 1)) begin errors++; $display("FAIL cycles_count got %h exp %h", mem_rdata, 16'(k + 1)); end
  endtask

  task automatic test_reset_mid_drain();
    step(1'b1, 16'hFF00, 16'h5A5A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hFF01, 16'(8'h61 + i), 1'b1, 1'b0);
    step(1'b1, 16'h0005, 16'h0, 1'b0, 1'b0);
    checks++; if (tx_valid !== 1'b1 || gpio_out !== 16'h5A5A) begin errors++; $display("FAIL pre_reset got %b/%h exp 1/5a5a", tx_valid, gpio_out); end
    do_reset(1'b1);
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin errors++; $display("FAIL midrst_tx got %b/%h exp 0/00", tx_valid, tx_data); end
    checks++; if (gpio_out !== 16'h0 || mem_rdata !== 16'h0) begin errors++; $display("FAIL midrst_regs got %h/%h exp 0000/0000", gpio_out, mem_rdata); end
    step(1'b1, 16'hFF03, 16'h0, 1'b0, 1'b1);
    checks++; if (mem_rdata !== 16'h0 || tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_cycles got %h/%b exp 0000/0", mem_rdata, tx_valid); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    int          sel;
    logic        we;
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'($urandom), 1'b1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      we  = $urandom_range(0, 1);
      case (sel)
        0, 1, 2, 3: a = 16'($urandom_range(0, 7));
        4:          a = 16'hFF00;
        5, 6:       a = 16'hFF01;
        7:          a = 16'hFF02;
        8:          a = 16'hFF03;
        default:    a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0100, 16'hFEFF))
                                                    : 16'($urandom_range(16'hFF04, 16'hFFFF));
      endcase
      step($urandom_range(0, 3) != 0, a, 16'($urandom), we, $urandom_range(0, 2) == 0);
      checks++;
      if (mem_rdata !== rdata_m || gpio_out !== gpio_m || tx_valid !== (q.size() > 0) || tx_data !== head_m()) begin
        errors++;
        $display("FAIL random_%0d got rd=%h gpio=%h v=%b d=%h exp rd=%h gpio=%h v=%b d=%h", n,
                 mem_rdata, gpio_out, tx_valid, tx_data, rdata_m, gpio_m, q.size() > 0, head_m());
      end
    end
    step(1'b1, 16'hFF02, 16'h0, 1'b0, 1'b0);
    checks++; if (mem_rdata !== rdata_m) begin errors++; $display("FAIL random_status got %h exp %h", mem_rdata, rdata_m); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_tx_overflow();
    test_drain();
    test_unmapped();
    test_push_pop_full();
    test_cycles();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
